// File: rtl/shared_ram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// shared_ram_arbiter_pkg
// Shared definitions for the main-RAM arbiter slice: slot owner enumeration,
// slot sequencer state encoding, RAM geometry and slot length.
// No ports (package).
// ---------------------------------------------------------------------------
package shared_ram_arbiter_pkg;

    // 32 KiB main RAM
    localparam int RAM_AW   = 15;

    // Every granted slot walks IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE
    localparam int SLOT_LEN = 4;

    // Who owns the RAM port for the slot currently in flight
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_VIDEO = 2'd1,
        OWN_CPU   = 2'd2,
        OWN_AUX   = 2'd3
    } owner_t;

    // Slot sequencer states; CAPTURE is the last cycle of a slot
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_CAPTURE = 2'(SLOT_LEN - 1);

endpackage

// File: rtl/shared_ram_arbiter_aux_starve_counter.sv
// ---------------------------------------------------------------------------
// shared_ram_arbiter_aux_starve_counter
// Counts consecutive CPU slots in which a pending aux request was denied.
// Saturates at TIMEOUT and raises a sticky aux_starved flag when it gets
// there. Cleared by an aux grant or by the requester dropping a_req.
//
// Ports:
//   clk         in   pixel clock
//   nRESET      in   synchronous active-low reset
//   cpu_slot    in   a CPU slot (v_turn=0) was accepted this cycle
//   aux_grant   in   the accepted slot was granted to aux
//   a_req       in   aux request level
//   aux_starved out  sticky starvation flag
// ---------------------------------------------------------------------------
module shared_ram_arbiter_aux_starve_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic nRESET,
    input  logic cpu_slot,
    input  logic aux_grant,
    input  logic a_req,
    output logic aux_starved
);

    localparam int             CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] count;

    // A denied CPU slot bumps the count until it saturates at the limit.
    // The flag is raised on the same edge the count reaches the limit and
    // then holds until reset, whatever happens to the count afterwards.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            count       <= '0;
            aux_starved <= 1'b0;
        end else begin
            if (aux_grant || !a_req) begin
                count <= '0;
            end else if (cpu_slot && count != LIMIT) begin
                count <= count + 1'b1;
                if (count == LIMIT - 1'b1) begin
                    aux_starved <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/shared_ram_arbiter.sv
// ---------------------------------------------------------------------------
// shared_ram_arbiter
// Owns the single port of the 32 KiB main RAM and shares it between video
// fetch, the 6502 and an auxiliary DMA/loader port. One slot is granted per
// ram_en strobe; each slot is sequenced through issue, wait and capture and
// the read data is returned to the owning requester.
//
// Optional feature macro: AUX_VBLANK_STEAL_EN
//   defined   -> a video slot during vblank with a_req=1 goes to aux
//   undefined -> vblank is ignored, video slots always belong to video
//
// Ports:
//   clk, nRESET               pixel clock, synchronous active-low reset
//   ram_en                    slot strobe (one clk wide)
//   v_turn                    current slot belongs to video
//   phi_2                     CPU phase 2 (CPU writes only when high)
//   vblank                    vertical blanking (optional feature only)
//   v_addr / v_data / v_valid video read port
//   p_addr / p_rnw / p_wdata / p_rdata   CPU port (RAM when p_addr[15]=0)
//   a_req / a_we / a_addr / a_wdata / a_ack / a_rdata   aux handshake port
//   mem_addr / mem_we / mem_wdata / mem_rdata   RAM port (1-cycle read)
//   aux_starved, slot_overrun sticky status flags
// ---------------------------------------------------------------------------
module shared_ram_arbiter
    import shared_ram_arbiter_pkg::*;
#(
    parameter int AW          = RAM_AW,
    parameter int DW          = 8,
    parameter int AUX_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          ram_en,
    input  logic          v_turn,
    input  logic          phi_2,
    input  logic          vblank,
    input  logic [AW-1:0] v_addr,
    output logic [DW-1:0] v_data,
    output logic          v_valid,
    input  logic [15:0]   p_addr,
    input  logic          p_rnw,
    input  logic [DW-1:0] p_wdata,
    output logic [DW-1:0] p_rdata,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_ack,
    output logic [DW-1:0] a_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          aux_starved,
    output logic          slot_overrun
);

    logic [1:0]    state;
    owner_t        owner;
    logic          slot_write;

    owner_t        next_owner;
    logic          next_write;
    logic [AW-1:0] next_addr;
    logic [DW-1:0] next_wdata;

    logic          slot_start;
    logic          cpu_slot;
    logic          aux_grant;

    assign slot_start = (state == ST_IDLE) && ram_en;
    assign cpu_slot   = slot_start && !v_turn;
    assign aux_grant  = slot_start && (next_owner == OWN_AUX);

`ifndef AUX_VBLANK_STEAL_EN
    logic unused_vblank;
    assign unused_vblank = vblank;
`endif

    // Decide who would own a slot starting now. Video always wins its own
    // turn; in a CPU turn the CPU keeps the slot whenever it is addressing
    // RAM, so aux only ever picks up CPU slots spent on ROM/IO. With the
    // vblank steal feature a pending aux request may also take a video slot
    // while the display is blanked.
    always_comb begin
        next_owner = OWN_NONE;
        next_write = 1'b0;
        next_addr  = '0;
        next_wdata = '0;
        if (v_turn) begin
            next_owner = OWN_VIDEO;
            next_addr  = v_addr;
`ifdef AUX_VBLANK_STEAL_EN
            if (vblank && a_req) begin
                next_owner = OWN_AUX;
                next_write = a_we;
                next_addr  = a_addr;
                next_wdata = a_wdata;
            end
`endif
        end else if (!p_addr[15]) begin
            next_owner = OWN_CPU;
            next_write = ~p_rnw & phi_2;
            next_addr  = AW'(p_addr[14:0]);
            next_wdata = p_wdata;
        end else if (a_req) begin
            next_owner = OWN_AUX;
            next_write = a_we;
            next_addr  = a_addr;
            next_wdata = a_wdata;
        end
    end

    // Slot sequencer. The owner and RAM command are latched on the strobe
    // edge so mem_* are valid for the ISSUE cycle, with mem_we high for that
    // cycle only. The RAM answers one cycle after it sees the address, so
    // read data is taken at the end of WAIT and the owner's data/pulse is
    // visible during CAPTURE. An empty slot (no owner) just spends one
    // cycle in ISSUE and returns to IDLE. A strobe that lands mid-slot is
    // dropped and only recorded in slot_overrun.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state        <= ST_IDLE;
            owner        <= OWN_NONE;
            slot_write   <= 1'b0;
            mem_addr     <= '0;
            mem_we       <= 1'b0;
            mem_wdata    <= '0;
            v_data       <= '0;
            v_valid      <= 1'b0;
            p_rdata      <= '0;
            a_ack        <= 1'b0;
            a_rdata      <= '0;
            slot_overrun <= 1'b0;
        end else begin
            mem_we  <= 1'b0;
            v_valid <= 1'b0;
            a_ack   <= 1'b0;

            if (ram_en && state != ST_IDLE) begin
                slot_overrun <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (ram_en) begin
                        state      <= ST_ISSUE;
                        owner      <= next_owner;
                        slot_write <= next_write;
                        if (next_owner != OWN_NONE) begin
                            mem_addr <= next_addr;
                            mem_we   <= next_write;
                        end
                        if (next_write) begin
                            mem_wdata <= next_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    state <= (owner == OWN_NONE) ? ST_IDLE : ST_WAIT;
                end
                ST_WAIT: begin
                    state <= ST_CAPTURE;
                    case (owner)
                        OWN_VIDEO: begin
                            v_data  <= mem_rdata;
                            v_valid <= 1'b1;
                        end
                        OWN_CPU: begin
                            if (!slot_write) begin
                                p_rdata <= mem_rdata;
                            end
                        end
                        OWN_AUX: begin
                            a_ack <= 1'b1;
                            if (!slot_write) begin
                                a_rdata <= mem_rdata;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    shared_ram_arbiter_aux_starve_counter #(
        .TIMEOUT(AUX_TIMEOUT)
    ) u_aux_starve_counter (
        .clk        (clk),
        .nRESET     (nRESET),
        .cpu_slot   (cpu_slot),
        .aux_grant  (aux_grant),
        .a_req      (a_req),
        .aux_starved(aux_starved)
    );

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shared_ram_arbiter
// Bench for shared_ram_arbiter with a small synchronous RAM attached to the
// mem_* port, a slot-level reference model and a per-cycle comparator.
// Honours AUX_VBLANK_STEAL_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_shared_ram_arbiter;

    localparam int TIMEOUT = 4;

    bit          clk;
    logic        nRESET;
    logic        ram_en;
    logic        v_turn;
    logic        phi_2;
    logic        vblank;
    logic [14:0] v_addr;
    logic [7:0]  v_data;
    logic        v_valid;
    logic [15:0] p_addr;
    logic        p_rnw;
    logic [7:0]  p_wdata;
    logic [7:0]  p_rdata;
    logic        a_req;
    logic        a_we;
    logic [14:0] a_addr;
    logic [7:0]  a_wdata;
    logic        a_ack;
    logic [7:0]  a_rdata;
    logic [14:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        aux_starved;
    logic        slot_overrun;

    int tests;
    int failures;

    shared_ram_arbiter #(
        .AW(15), .DW(8), .AUX_TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .nRESET(nRESET), .ram_en(ram_en), .v_turn(v_turn),
        .phi_2(phi_2), .vblank(vblank), .v_addr(v_addr), .v_data(v_data),
        .v_valid(v_valid), .p_addr(p_addr), .p_rnw(p_rnw), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .a_req(a_req), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .aux_starved(aux_starved),
        .slot_overrun(slot_overrun)
    );

    always #5 clk = ~clk;

    // Main RAM: synchronous, read-before-write, one cycle read latency
    logic [7:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Reference model: tracks slots in whole-slot terms (start edge, owner,
    // age) and a private copy of RAM contents; expected outputs describe the
    // values that must be visible after each rising edge.
    logic [7:0]  ref_mem [0:32767];
    int          mdl_edge;
    bit          mdl_busy;
    int          mdl_start;
    int          mdl_own;
    bit          mdl_wr;
    logic [14:0] mdl_addr;
    int          mdl_denied;
    int          n_own;
    bit          n_wr;
    logic [14:0] n_addr;
    logic [7:0]  n_wdata;
    logic        exp_mem_we, exp_v_valid, exp_a_ack, exp_aux_starved, exp_slot_overrun;
    logic [14:0] exp_mem_addr;
    logic [7:0]  exp_mem_wdata, exp_v_data, exp_p_rdata, exp_a_rdata;

    always @(posedge clk) begin
        mdl_edge++;
        if (!nRESET) begin
            mdl_busy = 0; mdl_denied = 0;
            exp_mem_we = 0; exp_v_valid = 0; exp_a_ack = 0;
            exp_aux_starved = 0; exp_slot_overrun = 0;
            exp_mem_addr = 0; exp_mem_wdata = 0; exp_v_data = 0;
            exp_p_rdata = 0; exp_a_rdata = 0;
        end else begin
            exp_mem_we = 0; exp_v_valid = 0; exp_a_ack = 0;
            if (!a_req) mdl_denied = 0;
            if (mdl_busy && (mdl_edge - mdl_start) == 2) begin
                if (mdl_own == 1) begin
                    exp_v_valid = 1;
                    exp_v_data  = ref_mem[mdl_addr];
                end else if (mdl_own == 2 && !mdl_wr) begin
                    exp_p_rdata = ref_mem[mdl_addr];
                end else if (mdl_own == 3) begin
                    exp_a_ack = 1;
                    if (!mdl_wr) exp_a_rdata = ref_mem[mdl_addr];
                end
            end
            if (ram_en) begin
                if (mdl_busy && (mdl_edge - mdl_start) < ((mdl_own == 0) ? 2 : 4)) begin
                    exp_slot_overrun = 1;
                end else begin
                    n_own = 0; n_wr = 0; n_addr = 0; n_wdata = 0;
                    if (v_turn) begin
                        n_own = 1; n_addr = v_addr;
`ifdef AUX_VBLANK_STEAL_EN
                        if (vblank && a_req) begin
                            n_own = 3; n_wr = a_we; n_addr = a_addr; n_wdata = a_wdata;
                        end
`endif
                    end else if (p_addr[15] == 1'b0) begin
                        n_own = 2; n_wr = !p_rnw && phi_2; n_addr = p_addr[14:0]; n_wdata = p_wdata;
                    end else if (a_req) begin
                        n_own = 3; n_wr = a_we; n_addr = a_addr; n_wdata = a_wdata;
                    end
                    mdl_busy = 1; mdl_start = mdl_edge; mdl_own = n_own;
                    mdl_wr = n_wr; mdl_addr = n_addr;
                    if (n_own != 0) begin
                        exp_mem_addr = n_addr;
                        exp_mem_we   = n_wr;
                    end
                    if (n_wr) begin
                        exp_mem_wdata   = n_wdata;
                        ref_mem[n_addr] = n_wdata;
                    end
                    if (n_own == 3) begin
                        mdl_denied = 0;
                    end else if (!v_turn && a_req) begin
                        if (mdl_denied < TIMEOUT) mdl_denied++;
                        if (mdl_denied >= TIMEOUT) exp_aux_starved = 1;
                    end
                end
            end
        end
    end

    // Per-cycle comparator, sampling mid-cycle
    bit cmp_on = 1'b1;
    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("mem_we", mem_we, exp_mem_we);
            checkOutput("mem_addr", mem_addr, exp_mem_addr);
            checkOutput("mem_wdata", mem_wdata, exp_mem_wdata);
            checkOutput("v_valid", v_valid, exp_v_valid);
            checkOutput("v_data", v_data, exp_v_data);
            checkOutput("p_rdata", p_rdata, exp_p_rdata);
            checkOutput("a_ack", a_ack, exp_a_ack);
            checkOutput("a_rdata", a_rdata, exp_a_rdata);
            checkOutput("aux_starved", aux_starved, exp_aux_starved);
            checkOutput("slot_overrun", slot_overrun, exp_slot_overrun);
        end
    end

    // Observations of the most recent slot, indexed by cycle after strobe
    logic        obs_we1;
    logic [14:0] obs_addr1;
    logic        obs_we_other;
    logic        obs_valid3;
    logic [7:0]  obs_vdata3;
    logic        obs_ack3;
    logic        obs_ack_any;
    logic        obs_valid_any;

    // Start one slot from a negedge and run it to completion, leaving the
    // bench on the negedge after the slot's last cycle
    task automatic applyStimulus(input logic vt, input logic [15:0] pa,
                                 input logic rnw, input logic ph2,
                                 input logic [7:0] pw, input logic vb,
                                 input logic [14:0] va);
        v_turn = vt; p_addr = pa; p_rnw = rnw; phi_2 = ph2;
        p_wdata = pw; vblank = vb; v_addr = va;
        ram_en = 1'b1;
        obs_we_other = 0; obs_ack_any = 0; obs_valid_any = 0;
        obs_we1 = 0; obs_addr1 = 0; obs_valid3 = 0; obs_vdata3 = 0; obs_ack3 = 0;
        @(posedge clk);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                ram_en    = 1'b0;
                obs_we1   = mem_we;
                obs_addr1 = mem_addr;
            end else begin
                obs_we_other = obs_we_other | mem_we;
            end
            if (i == 3) begin
                obs_valid3 = v_valid;
                obs_vdata3 = v_data;
                obs_ack3   = a_ack;
            end
            obs_ack_any   = obs_ack_any | a_ack;
            obs_valid_any = obs_valid_any | v_valid;
        end
    endtask

    bit aux_hold;

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        ram[15'h1234]     = 8'hA5;
        ref_mem[15'h1234] = 8'hA5;

        nRESET = 0; ram_en = 0; v_turn = 0; phi_2 = 0; vblank = 0;
        v_addr = 0; p_addr = 16'h8000; p_rnw = 1; p_wdata = 0;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        repeat (3) @(negedge clk);
        checkOutput("reset_mem_we", mem_we, 1'b0);
        checkOutput("reset_v_valid", v_valid, 1'b0);
        checkOutput("reset_mem_addr", mem_addr, 15'h0);
        checkOutput("reset_flags", {aux_starved, slot_overrun}, 2'b00);
        nRESET = 1;
        @(negedge clk);

        $display("[TB] video read");
        applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, 8'h00, 1'b0, 15'h1234);
        checkOutput("video_valid_n3", obs_valid3, 1'b1);
        checkOutput("video_data", obs_vdata3, 8'hA5);
        checkOutput("video_no_we", obs_we1 | obs_we_other, 1'b0);

        $display("[TB] cpu write then read");
        applyStimulus(1'b0, 16'h0100, 1'b0, 1'b1, 8'h3C, 1'b0, 15'h0);
        checkOutput("cpu_we_n1", obs_we1, 1'b1);
        checkOutput("cpu_addr_n1", obs_addr1, 15'h0100);
        checkOutput("cpu_we_only_n1", obs_we_other, 1'b0);
        applyStimulus(1'b0, 16'h0100, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
        checkOutput("cpu_readback", p_rdata, 8'h3C);

        $display("[TB] aux waits for cpu");
        a_req = 1; a_we = 1; a_addr = 15'h7FFF; a_wdata = 8'h11;
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1'b0, 16'h2000, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
            checkOutput("aux_blocked", obs_ack_any, 1'b0);
        end
        applyStimulus(1'b0, 16'hC000, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
        checkOutput("aux_ack_n3", obs_ack3, 1'b1);
        checkOutput("aux_ram_write", ram[15'h7FFF], 8'h11);
        a_req = 0;

        $display("[TB] starvation");
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 15'h0055;
        for (int s = 0; s < 3; s++)
            applyStimulus(1'b0, 16'h0200, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
        checkOutput("starved_after_3", aux_starved, 1'b0);
        applyStimulus(1'b0, 16'h0200, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
        checkOutput("starved_after_4", aux_starved, 1'b1);
        applyStimulus(1'b0, 16'h8000, 1'b1, 1'b1, 8'h00, 1'b0, 15'h0);
        checkOutput("starved_grant_ack", obs_ack3, 1'b1);
        checkOutput("starved_read_data", a_rdata, 8'h55 ^ 8'h5A);
        checkOutput("starved_sticky", aux_starved, 1'b1);
        a_req = 0;

        $display("[TB] overrun");
        v_turn = 1; v_addr = 15'h1234; vblank = 0; ram_en = 1;
        @(posedge clk);
        @(negedge clk); ram_en = 0;
        @(negedge clk); ram_en = 1;
        @(posedge clk);
        @(negedge clk); ram_en = 0;
        checkOutput("overrun_first_valid", v_valid, 1'b1);
        checkOutput("overrun_first_data", v_data, 8'hA5);
        checkOutput("overrun_flag", slot_overrun, 1'b1);
        repeat (2) @(negedge clk);

        $display("[TB] vblank steal");
        a_req = 1; a_we = 0; a_addr = 15'h1234;
        applyStimulus(1'b1, 16'h8000, 1'b1, 1'b0, 8'h00, 1'b1, 15'h0042);
`ifdef AUX_VBLANK_STEAL_EN
        checkOutput("steal_ack", obs_ack3, 1'b1);
        checkOutput("steal_no_valid", obs_valid_any, 1'b0);
        checkOutput("steal_rdata", a_rdata, 8'hA5);
`else
        checkOutput("nosteal_valid", obs_valid3, 1'b1);
        checkOutput("nosteal_no_ack", obs_ack_any, 1'b0);
        checkOutput("nosteal_data", obs_vdata3, 8'h42 ^ 8'h5A);
`endif
        a_req = 0;

        $display("[TB] reset mid-slot");
        v_turn = 0; p_addr = 16'h0300; p_rnw = 0; phi_2 = 1; p_wdata = 8'h77;
        ram_en = 1;
        @(posedge clk);
        @(negedge clk); ram_en = 0; nRESET = 0;
        @(negedge clk);
        checkOutput("rst_mem_we", mem_we, 1'b0);
        checkOutput("rst_overrun", slot_overrun, 1'b0);
        checkOutput("rst_outputs", {v_data, p_rdata, a_rdata, v_valid, a_ack}, 26'h0);
        nRESET = 1;
        @(negedge clk);

        $display("[TB] random slots");
        aux_hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!aux_hold || $urandom_range(0, 15) == 0) begin
                a_req   = $urandom_range(0, 1);
                a_we    = $urandom_range(0, 1);
                a_addr  = 15'($urandom_range(0, 63));
                a_wdata = 8'($urandom);
            end
            applyStimulus($urandom_range(0, 3) == 0,
                          {1'($urandom_range(0, 1)), 9'h0, 6'($urandom_range(0, 63))},
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          8'($urandom), 1'($urandom_range(0, 1)),
                          15'($urandom_range(0, 63)));
            aux_hold = a_req && !obs_ack_any;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 80) == 0) begin
                nRESET = 0;
                @(negedge clk);
                nRESET = 1;
                @(negedge clk);
            end
        end

        cmp_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/shared_ram_arbiter.md
Name: shared_ram_arbiter

Overview:
- Owns the single port of the 32 KiB main RAM and shares it between three requesters: video fetch (CRTC framestore reads), the MOS6502, and an auxiliary DMA/loader port (SD-card image loader, debug poke).
- Sits between the Timing_Generator strobes and the RAM array, replacing the ad-hoc V_TURN read/write logic.
- Slots are granted per RAM_en strobe. The arbiter sequences each slot through issue and capture, and returns data to the owning requester.

Parameters:
- AW, 15, RAM address width (32 KiB).
- DW, 8, data width.
- AUX_TIMEOUT, 255, number of consecutive denied slots before aux_starved asserts.

Ports:
- clk  in  1  pixel clock.
- nRESET  in  1  synchronous active-low reset.
- ram_en  in  1  slot strobe, one clk wide.
- v_turn  in  1  high: current slot belongs to video.
- phi_2  in  1  CPU phase 2; CPU writes are legal only when high.
- vblank  in  1  vertical blanking (used only with the optional feature).
- v_addr  in  AW  video read address (already corrected).
- v_data  out  DW  video read data.
- v_valid  out  1  one-cycle pulse when v_data updates.
- p_addr  in  16  CPU address; RAM is selected when p_addr[15]=0.
- p_rnw  in  1  CPU read/not-write.
- p_wdata  in  DW  CPU write data.
- p_rdata  out  DW  CPU read data.
- a_req  in  1  aux request, level.
- a_we  in  1  aux write.
- a_addr  in  AW  aux address.
- a_wdata  in  DW  aux write data.
- a_ack  out  1  one-cycle pulse when an aux access completes.
- a_rdata  out  DW  aux read data, valid with a_ack.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write enable.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; synchronous, one-cycle latency.
- aux_starved  out  1  sticky flag.
- slot_overrun  out  1  sticky flag.

Behaviour:
- Reset values: all outputs 0, state IDLE, starvation counter 0.
- States: IDLE -> ISSUE -> WAIT -> CAPTURE -> IDLE. Each slot takes 4 clk; ram_en strobes must be at least 4 clk apart.
- A slot starts on a clk edge in IDLE with ram_en=1. The owner is latched on that edge:
  - v_turn=1: VIDEO. Read v_addr.
  - v_turn=0 and p_addr[15]=0: CPU. Write if ~p_rnw & phi_2, otherwise read p_addr[14:0].
  - v_turn=0 and p_addr[15]=1 and a_req=1: AUX.
  - Otherwise: NONE. Return to IDLE next cycle; mem_we stays 0.
- Address and write data are registered onto mem_* in ISSUE (cycle N+1 after the strobe at N). mem_we is high for exactly that one cycle.
- For reads, mem_rdata is sampled in CAPTURE (N+3) into the owner's data register:
  - v_valid pulses at N+3 for VIDEO.
  - a_ack pulses at N+3 for AUX, for both reads and writes.
  - p_rdata holds its value until the next CPU read.
- Aux handshake:
  - a_req must stay high and aux inputs must stay stable until a_ack.
  - Exactly one access is performed per a_ack.
  - If a_req drops before grant, nothing is issued.
- CPU is never pre-empted. Aux only uses CPU slots in which the CPU is not addressing RAM.
- Starvation counter:
  - Increments on each CPU-slot strobe where a_req=1 and aux is not granted. Saturates.
  - Resets to 0 on aux grant or when a_req=0.
  - aux_starved sets when the counter reaches AUX_TIMEOUT.
- ram_en arriving while not IDLE:
  - The strobe is ignored and the in-flight slot completes normally.
  - slot_overrun sets.
- Sticky flags clear only on reset.
- Reset mid-slot aborts immediately: mem_we=0, no ack or valid pulse.
- A pending aux request is re-arbitrated after reset only if a_req is still high.

Optional Feature:
- Macro AUX_VBLANK_STEAL_EN.
- Enabled: a video slot with vblank=1 and a_req=1 is granted to AUX instead of VIDEO; v_valid does not pulse for that slot.
- Disabled: vblank is ignored and video slots are always VIDEO.

Decomposition:
- Shared package holds:
  - owner enumeration: OWN_NONE, OWN_VIDEO, OWN_CPU, OWN_AUX;
  - state enumeration;
  - constants for RAM address width and slot length (4).
- One natural sub-module: aux_starve_counter (saturating counter plus sticky flag).

Test Plan:
- Video read: RAM[0x1234]=0xA5, v_turn=1, v_addr=0x1234, ram_en at N -> v_valid pulse at N+3, v_data=0xA5, mem_we never high.
- CPU write then read: v_turn=0, p_addr=0x0100, p_rnw=0, phi_2=1, p_wdata=0x3C -> mem_we high at N+1 only, mem_addr=0x0100. Next CPU read of the same address -> p_rdata=0x3C.
- Aux waits for CPU: a_req=1, a_we=1, a_addr=0x7FFF, a_wdata=0x11 held while p_addr=0x2000 for 3 CPU slots -> no a_ack. When p_addr=0xC000 -> a_ack at N+3, RAM[0x7FFF]=0x11.
- Starvation: AUX_TIMEOUT=4, a_req held, CPU always in RAM -> aux_starved=1 after the 4th denied CPU slot, and stays set after a later grant.
- Overrun and reset: ram_en at N and N+2 -> slot_overrun=1 and the first slot completes. Separately, nRESET=0 at N+1 of a write slot -> mem_we=0 and all outputs 0 on the next edge.
- With AUX_VBLANK_STEAL_EN: v_turn=1, vblank=1, a_req=1 -> a_ack at N+3, no v_valid. Without the macro, same stimulus -> v_valid and no a_ack.
